// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants and decode helper
package seg7_pkg;

    localparam logic [7:0] SEG7_D0  = 8'h3F;
    localparam logic [7:0] SEG7_D1  = 8'h06;
    localparam logic [7:0] SEG7_D2  = 8'h5B;
    localparam logic [7:0] SEG7_D3  = 8'h4F;
    localparam logic [7:0] SEG7_D4  = 8'h66;
    localparam logic [7:0] SEG7_D5  = 8'h6D;
    localparam logic [7:0] SEG7_D6  = 8'h7D;
    localparam logic [7:0] SEG7_D7  = 8'h07;
    localparam logic [7:0] SEG7_D8  = 8'h7F;
    localparam logic [7:0] SEG7_D9  = 8'h67;
    localparam logic [7:0] SEG7_OVF = 8'h80;

    localparam logic [3:0] DIGIT_OVF = 4'hF;
    localparam logic [3:0] DIGIT_INV = 4'hE;

    typedef struct packed {
        logic [3:0] digit;
        logic       ovf;
        logic       inv;
    } seg7_decode_t;

    // Only exact matches are legal; a decimal point on top of a digit is invalid.
    function automatic seg7_decode_t seg7_decode(input logic [7:0] pattern);
        seg7_decode_t r;
        r = '{DIGIT_INV, 1'b0, 1'b1};
        case (pattern)
            SEG7_D0:  r = '{4'd0, 1'b0, 1'b0};
            SEG7_D1:  r = '{4'd1, 1'b0, 1'b0};
            SEG7_D2:  r = '{4'd2, 1'b0, 1'b0};
            SEG7_D3:  r = '{4'd3, 1'b0, 1'b0};
            SEG7_D4:  r = '{4'd4, 1'b0, 1'b0};
            SEG7_D5:  r = '{4'd5, 1'b0, 1'b0};
            SEG7_D6:  r = '{4'd6, 1'b0, 1'b0};
            SEG7_D7:  r = '{4'd7, 1'b0, 1'b0};
            SEG7_D8:  r = '{4'd8, 1'b0, 1'b0};
            SEG7_D9:  r = '{4'd9, 1'b0, 1'b0};
            SEG7_OVF: r = '{DIGIT_OVF, 1'b1, 1'b0};
            default:  r = '{DIGIT_INV, 1'b0, 1'b1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder_if.sv
// rtl/seg7_pattern_decoder_if.sv - pattern input / decode result bundle (history under SEG7_DEC_HISTORY_EN)
interface seg7_pattern_decoder_if;
    logic [7:0] seg_in;
    logic       clr_count;
    logic [3:0] digit;
    logic       digit_valid;
    logic       overflow;
    logic       invalid;
    logic [7:0] accept_count;
`ifdef SEG7_DEC_HISTORY_EN
    logic [7:0] history;
`endif

    modport master (
        output seg_in, clr_count,
`ifdef SEG7_DEC_HISTORY_EN
        input  history,
`endif
        input  digit, digit_valid, overflow, invalid, accept_count
    );

    modport slave (
        input  seg_in, clr_count,
`ifdef SEG7_DEC_HISTORY_EN
        output history,
`endif
        output digit, digit_valid, overflow, invalid, accept_count
    );
endinterface

// File: rtl/seg7_stability_filter.sv
// rtl/seg7_stability_filter.sv - run-length debounce; flags the edge a run reaches STABLE_CYCLES
module seg7_stability_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    output logic       accept,
    output logic [7:0] pattern
);
    localparam logic [3:0] RL_MAX = 4'(STABLE_CYCLES);

    logic [7:0] prev_seg;
    logic [3:0] rl;
    logic       same;

    // rl==0 only right after reset, so the first sample always opens a new run.
    assign same    = (rl != 4'd0) && (seg_in == prev_seg);
    assign accept  = same ? (rl == RL_MAX - 4'd1) : (RL_MAX == 4'd1);
    assign pattern = seg_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_seg <= 8'h00;
            rl       <= 4'd0;
        end else if (same) begin
            if (rl < RL_MAX) rl <= rl + 4'd1;
        end else begin
            prev_seg <= seg_in;
            rl       <= 4'd1;
        end
    end
endmodule

// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - debounced 7-segment decoder with good-digit counter; SEG7_DEC_HISTORY_EN adds history
module seg7_pattern_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_pattern_decoder_if.slave bus
);
    logic         accept;
    logic [7:0]   pattern;
    seg7_decode_t dec;
    logic         legal;

    seg7_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (bus.seg_in),
        .accept  (accept),
        .pattern (pattern)
    );

    assign dec   = seg7_decode(pattern);
    assign legal = !dec.ovf && !dec.inv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.digit        <= 4'd0;
            bus.digit_valid  <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.invalid      <= 1'b0;
            bus.accept_count <= 8'd0;
        end else begin
            bus.digit_valid <= accept;
            if (accept) begin
                bus.digit    <= dec.digit;
                bus.overflow <= dec.ovf;
                bus.invalid  <= dec.inv;
            end
            // Clear wins over a coincident increment.
            if (bus.clr_count)
                bus.accept_count <= 8'd0;
            else if (accept && legal && bus.accept_count != 8'hFF)
                bus.accept_count <= bus.accept_count + 8'd1;
        end
    end

`ifdef SEG7_DEC_HISTORY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.history <= 8'h00;
        else if (bus.clr_count)
            bus.history <= 8'h00;
        else if (accept && legal)
            bus.history <= {bus.history[3:0], dec.digit};
    end
`endif
endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb/tb_seg7_pattern_decoder.sv - scoreboard bench for seg7_pattern_decoder (STABLE_CYCLES 4 and 1)
module tb_seg7_pattern_decoder;

    typedef struct {
        logic [3:0] d;
        logic       ovf;
        logic       inv;
        logic [7:0] cnt;
        logic [7:0] hist;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] hist_a = 8'h00;
    logic [7:0] hist_b = 8'h00;

    always #5 clk = ~clk;

    seg7_pattern_decoder_if bus_a ();
    seg7_pattern_decoder_if bus_b ();

    seg7_pattern_decoder #(.STABLE_CYCLES(4)) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
    seg7_pattern_decoder #(.STABLE_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit sel_b, input logic [3:0] d, input logic ovf, input logic inv,
                        input logic [7:0] cnt, input bit clr);
        exp_t e;
        logic [7:0] h;
        h = sel_b ? hist_b : hist_a;
        if (clr) h = 8'h00;
        else if (!ovf && !inv) h = {h[3:0], d};
        e = '{d, ovf, inv, cnt, h};
        if (sel_b) begin hist_b = h; q_b.push_back(e); end
        else begin hist_a = h; q_a.push_back(e); end
    endtask

    task automatic hold_a(input logic [7:0] pat, input int n, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            bus_a.seg_in    = pat;
            bus_a.clr_count = clr_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        bus_a.clr_count = 1'b0;
    endtask

    task automatic step_b(input logic [7:0] pat);
        bus_b.seg_in = pat;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag, input logic [3:0] d, input logic v, input logic o,
                               input logic iv, input logic [7:0] c);
        check({tag, "_digit"}, 32'(d), 32'h0);
        check({tag, "_valid"}, 32'(v), 32'h0);
        check({tag, "_ovf"}, 32'(o), 32'h0);
        check({tag, "_inv"}, 32'(iv), 32'h0);
        check({tag, "_count"}, 32'(c), 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.digit_valid) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'h1, 32'h0);
            end else begin
                e = q_a.pop_front();
                check("a_digit", 32'(bus_a.digit), 32'(e.d));
                check("a_ovf", 32'(bus_a.overflow), 32'(e.ovf));
                check("a_inv", 32'(bus_a.invalid), 32'(e.inv));
                check("a_count", 32'(bus_a.accept_count), 32'(e.cnt));
`ifdef SEG7_DEC_HISTORY_EN
                check("a_hist", 32'(bus_a.history), 32'(e.hist));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.digit_valid) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_valid", 32'h1, 32'h0);
            end else begin
                e = q_b.pop_front();
                check("b_digit", 32'(bus_b.digit), 32'(e.d));
                check("b_ovf", 32'(bus_b.overflow), 32'(e.ovf));
                check("b_inv", 32'(bus_b.invalid), 32'(e.inv));
                check("b_count", 32'(bus_b.accept_count), 32'(e.cnt));
`ifdef SEG7_DEC_HISTORY_EN
                check("b_hist", 32'(bus_b.history), 32'(e.hist));
`endif
            end
        end
    end

    initial begin
        bus_a.seg_in = 8'h00;
        bus_a.clr_count = 1'b0;
        bus_b.seg_in = 8'h4F;
        bus_b.clr_count = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("a_rst", bus_a.digit, bus_a.digit_valid, bus_a.overflow, bus_a.invalid, bus_a.accept_count);
        check_reset("b_rst", bus_b.digit, bus_b.digit_valid, bus_b.overflow, bus_b.invalid, bus_b.accept_count);
        @(posedge clk);
        #1;
        rst_a = 1'b1;

        // 00 held out of reset is one invalid acceptance
        push(0, 4'hE, 0, 1, 8'd0, 0);  hold_a(8'h00, 4, 0);
        push(0, 4'd2, 0, 0, 8'd1, 0);  hold_a(8'h5B, 6, 0);
        push(0, 4'd1, 0, 0, 8'd2, 0);  hold_a(8'h06, 4, 0);
        hold_a(8'h07, 1, 0);
        hold_a(8'h7D, 3, 0);
        push(0, 4'd1, 0, 0, 8'd3, 0);  hold_a(8'h06, 4, 0);
        push(0, 4'hF, 1, 0, 8'd3, 0);  hold_a(8'h80, 4, 0);
        push(0, 4'hE, 0, 1, 8'd3, 0);  hold_a(8'h81, 4, 0);

        for (int i = 0; i < 300; i++) begin
            push(0, (i % 2 == 0) ? 4'd0 : 4'd9, 0, 0, (4 + i > 255) ? 8'd255 : 8'(4 + i), 0);
            hold_a((i % 2 == 0) ? 8'h3F : 8'h67, 4, 0);
        end
        @(negedge clk);
        check("a_saturated", 32'(bus_a.accept_count), 32'd255);
        #1;

        push(0, 4'd7, 0, 0, 8'd0, 1);  hold_a(8'h07, 4, 1);
        push(0, 4'd0, 0, 0, 8'd1, 0);  hold_a(8'h3F, 4, 0);
        hold_a(8'h3F, 1, 1);
        hist_a = 8'h00;
        @(negedge clk);
        check("a_clr_idle", 32'(bus_a.accept_count), 32'd0);
        #1;
        hold_a(8'h3F, 2, 0);

        push(0, 4'd7, 0, 0, 8'd1, 0);  hold_a(8'h07, 4, 0);
        push(0, 4'd9, 0, 0, 8'd2, 0);  hold_a(8'h67, 4, 0);
        push(0, 4'hF, 1, 0, 8'd2, 0);  hold_a(8'h80, 4, 0);
`ifdef SEG7_DEC_HISTORY_EN
        @(negedge clk);
        check("a_hist_after_ovf", 32'(bus_a.history), 32'h79);
        #1;
`endif

        hold_a(8'h66, 2, 0);
        rst_a = 1'b0;
        hist_a = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_reset("a_midrst", bus_a.digit, bus_a.digit_valid, bus_a.overflow, bus_a.invalid, bus_a.accept_count);
        #1;
        rst_a = 1'b1;
        push(0, 4'd4, 0, 0, 8'd1, 0);  hold_a(8'h66, 5, 0);

        rst_b = 1'b1;
        push(1, 4'd3, 0, 0, 8'd1, 0);  step_b(8'h4F);
        push(1, 4'd4, 0, 0, 8'd2, 0);  step_b(8'h66);
        step_b(8'h66);
        push(1, 4'd5, 0, 0, 8'd3, 0);  step_b(8'h6D);
        step_b(8'h6D);
        rst_b = 1'b0;
        hist_b = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_reset("b_midrst", bus_b.digit, bus_b.digit_valid, bus_b.overflow, bus_b.invalid, bus_b.accept_count);
        #1;
        rst_b = 1'b1;
        push(1, 4'd5, 0, 0, 8'd1, 0);  step_b(8'h6D);
        step_b(8'h6D);
        step_b(8'h6D);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
